// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer
//   Test controller that sits between a 65C02-class CPU core and its memory
//   model. It holds the CPU in reset after system reset, then injects an IRQ,
//   an NMI pulse and periodic RDY stalls on a parameterised schedule. It
//   watches the bus to decide when the test is over: a read of PASS_ADDR
//   means pass, a write to FAIL_ADDR means fail (the written byte is kept),
//   and running TIMEOUT cycles without either means timeout.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous reset, active-high
//   AB         in   CPU address bus
//   DO         in   CPU write data
//   RE, WE     in   CPU read / write enables
//   cpu_reset  out  reset to CPU, active-high
//   IRQ, NMI   out  interrupt requests to CPU, active-high
//   RDY        out  CPU ready, 0 stalls the CPU
//   done       out  test finished (sticky until reset)
//   pass/fail/timeout  out  which condition finished the test
//   fail_code  out  DO captured on the failing write
//   cycles     out  run cycles elapsed (saturating)
//
// state  | meaning
// -------+-----------------------------------------------------------
// HOLD   | CPU held in reset for RESET_CYCLES clocks
// RUN    | CPU running; schedule active, bus watched for termination
// DONE   | result latched; CPU back in reset until the next reset

module cpu_test_sequencer #(
    parameter int              AW           = 16,
    parameter int              DW           = 8,
    parameter int              CNT_W        = 32,
    parameter int              RESET_CYCLES = 4,
    parameter logic [AW-1:0]   PASS_ADDR    = 16'hBEEF,
    parameter logic [AW-1:0]   FAIL_ADDR    = 16'hDEAD,
    parameter logic [AW-1:0]   IRQ_VEC      = 16'hFFFE,
    parameter int              TIMEOUT      = 50000,
    parameter int              IRQ_AT       = 0,
    parameter int              NMI_AT       = 0,
    parameter int              NMI_LEN      = 2,
    parameter int              STALL_PERIOD = 0,
    parameter int              STALL_LEN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    AB,
    input  logic [DW-1:0]    DO,
    input  logic             RE,
    input  logic             WE,
    output logic             cpu_reset,
    output logic             IRQ,
    output logic             NMI,
    output logic             RDY,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [DW-1:0]    fail_code,
    output logic [CNT_W-1:0] cycles
);

    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
    localparam int PW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    // Schedule compares are made one cycle early so the registered output
    // is visible while cycles equals the programmed value.
    localparam logic [HW-1:0]    HOLD_LAST  = HW'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_M1      = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] IRQ_M1     = CNT_W'(IRQ_AT - 1);
    localparam logic [CNT_W-1:0] NMI_M1     = CNT_W'(NMI_AT - 1);
    localparam logic [CNT_W-1:0] NMI_LEN_M1 = CNT_W'(NMI_LEN - 1);
    localparam logic [PW-1:0]    PH_LAST    = PW'(STALL_PERIOD - 1);
    localparam logic [PW-1:0]    STALL_TH   = PW'(STALL_PERIOD - STALL_LEN);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [CNT_W-1:0]  nmi_cnt_q, nmi_cnt_d;
    logic              irq_fired_q, irq_fired_d;
    logic              nmi_fired_q, nmi_fired_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              irq_q, irq_d;
    logic              nmi_q, nmi_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              timeout_q, timeout_d;
    logic [DW-1:0]     fail_code_q, fail_code_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;

    logic hit_fail, hit_pass, hit_timeout, hit_irq_ack;

    // Bus matches only count when the CPU is not stalled in the same clock.
    assign hit_fail    = (state_q == S_RUN) && rdy_q && WE && (AB == FAIL_ADDR);
    assign hit_pass    = (state_q == S_RUN) && rdy_q && RE && (AB == PASS_ADDR);
    assign hit_timeout = (state_q == S_RUN) && (TIMEOUT != 0) && (cycles_q == TO_M1);
    assign hit_irq_ack = irq_q && rdy_q && RE && (AB == IRQ_VEC);

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        phase_d     = phase_q;
        nmi_cnt_d   = nmi_cnt_q;
        irq_fired_d = irq_fired_q;
        nmi_fired_d = nmi_fired_q;
        cpu_reset_d = cpu_reset_q;
        irq_d       = irq_q;
        nmi_d       = nmi_q;
        rdy_d       = rdy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        timeout_d   = timeout_q;
        fail_code_d = fail_code_q;
        cycles_d    = cycles_q;

        case (state_q)
            S_HOLD: begin
                cpu_reset_d = 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = S_RUN;
                    cpu_reset_d = 1'b0;
                    hold_cnt_d  = '0;
                    cycles_d    = '0;
                    phase_d     = '0;
                    rdy_d       = 1'b1;
                    irq_d       = 1'b0;
                    nmi_d       = 1'b0;
                    nmi_cnt_d   = '0;
                    irq_fired_d = 1'b0;
                    nmi_fired_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            S_RUN: begin
                if (hit_fail || hit_pass || hit_timeout) begin
                    // Termination freezes cycles at the value seen on the
                    // deciding clock; only the highest-priority flag is set.
                    state_d     = S_DONE;
                    cpu_reset_d = 1'b1;
                    irq_d       = 1'b0;
                    nmi_d       = 1'b0;
                    rdy_d       = 1'b1;
                    done_d      = 1'b1;
                    if (hit_fail) begin
                        fail_d      = 1'b1;
                        fail_code_d = DO;
                    end else if (hit_pass) begin
                        pass_d = 1'b1;
                    end else begin
                        timeout_d = 1'b1;
                    end
                end else begin
                    if (cycles_q != '1) begin
                        cycles_d = cycles_q + 1'b1;
                    end

                    if (STALL_PERIOD != 0) begin
                        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                        rdy_d   = (phase_d < STALL_TH);
                    end

                    if ((IRQ_AT != 0) && !irq_fired_q && (cycles_q == IRQ_M1)) begin
                        irq_d       = 1'b1;
                        irq_fired_d = 1'b1;
                    end else if (hit_irq_ack) begin
                        irq_d = 1'b0;
                    end

                    // NMI width is timed with a down-counter loaded on rise.
                    if ((NMI_AT != 0) && !nmi_fired_q && (cycles_q == NMI_M1)) begin
                        nmi_d       = 1'b1;
                        nmi_fired_d = 1'b1;
                        nmi_cnt_d   = NMI_LEN_M1;
                    end else if (nmi_q) begin
                        if (nmi_cnt_q == '0) begin
                            nmi_d = 1'b0;
                        end else begin
                            nmi_cnt_d = nmi_cnt_q - 1'b1;
                        end
                    end
                end
            end

            S_DONE: begin
                cpu_reset_d = 1'b1;
                irq_d       = 1'b0;
                nmi_d       = 1'b0;
                rdy_d       = 1'b1;
            end

            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HOLD;
            hold_cnt_q  <= '0;
            phase_q     <= '0;
            nmi_cnt_q   <= '0;
            irq_fired_q <= 1'b0;
            nmi_fired_q <= 1'b0;
            cpu_reset_q <= 1'b1;
            irq_q       <= 1'b0;
            nmi_q       <= 1'b0;
            rdy_q       <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= '0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            phase_q     <= phase_d;
            nmi_cnt_q   <= nmi_cnt_d;
            irq_fired_q <= irq_fired_d;
            nmi_fired_q <= nmi_fired_d;
            cpu_reset_q <= cpu_reset_d;
            irq_q       <= irq_d;
            nmi_q       <= nmi_d;
            rdy_q       <= rdy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            timeout_q   <= timeout_d;
            fail_code_q <= fail_code_d;
            cycles_q    <= cycles_d;
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign IRQ       = irq_q;
    assign NMI       = nmi_q;
    assign RDY       = rdy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign timeout   = timeout_q;
    assign fail_code = fail_code_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Bench for cpu_test_sequencer: three instances with different schedules
// share clock and reset. dut_a uses defaults, dut_b has a short watchdog and
// an idle bus, dut_c has stalls, IRQ and NMI scheduled.
module tb_cpu_test_sequencer;

    localparam int C_TO   = 120;
    localparam int C_IRQ  = 10;
    localparam int C_NMI  = 12;
    localparam int C_NLEN = 2;
    localparam int C_SP   = 4;
    localparam int C_SL   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] a_ab = '0, b_ab = '0, c_ab = '0;
    logic [7:0]  a_do = '0, b_do = '0, c_do = '0;
    logic        a_re = 0, a_we = 0, b_re = 0, b_we = 0, c_re = 0, c_we = 0;

    logic a_cr, a_irq, a_nmi, a_rdy, a_done, a_pass, a_fail, a_to;
    logic b_cr, b_irq, b_nmi, b_rdy, b_done, b_pass, b_fail, b_to;
    logic c_cr, c_irq, c_nmi, c_rdy, c_done, c_pass, c_fail, c_to;
    logic [7:0]  a_code, b_code, c_code;
    logic [31:0] a_cyc, b_cyc, c_cyc;

    cpu_test_sequencer dut_a (
        .clk(clk), .reset(rst), .AB(a_ab), .DO(a_do), .RE(a_re), .WE(a_we),
        .cpu_reset(a_cr), .IRQ(a_irq), .NMI(a_nmi), .RDY(a_rdy), .done(a_done),
        .pass(a_pass), .fail(a_fail), .timeout(a_to), .fail_code(a_code), .cycles(a_cyc)
    );

    cpu_test_sequencer #(.TIMEOUT(20)) dut_b (
        .clk(clk), .reset(rst), .AB(b_ab), .DO(b_do), .RE(b_re), .WE(b_we),
        .cpu_reset(b_cr), .IRQ(b_irq), .NMI(b_nmi), .RDY(b_rdy), .done(b_done),
        .pass(b_pass), .fail(b_fail), .timeout(b_to), .fail_code(b_code), .cycles(b_cyc)
    );

    cpu_test_sequencer #(
        .TIMEOUT(C_TO), .IRQ_AT(C_IRQ), .NMI_AT(C_NMI), .NMI_LEN(C_NLEN),
        .STALL_PERIOD(C_SP), .STALL_LEN(C_SL)
    ) dut_c (
        .clk(clk), .reset(rst), .AB(c_ab), .DO(c_do), .RE(c_re), .WE(c_we),
        .cpu_reset(c_cr), .IRQ(c_irq), .NMI(c_nmi), .RDY(c_rdy), .done(c_done),
        .pass(c_pass), .fail(c_fail), .timeout(c_to), .fail_code(c_code), .cycles(c_cyc)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Returns at the first negedge after reset released (first HOLD cycle).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_a_cycles(input int at);
        int k = 0;
        while (!(a_cr == 1'b0 && a_cyc == 32'(at)) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_a", 32'(a_cyc == 32'(at) && !a_cr), 1);
    endtask

    task automatic wait_c_cycles(input int at);
        int k = 0;
        while (!(c_cr == 1'b0 && c_cyc == 32'(at)) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("wait_c", 32'(c_cyc == 32'(at) && !c_cr), 1);
    endtask

    typedef struct {
        int          at;
        logic [15:0] ab;
        logic        re;
        logic        we;
        logic [7:0]  dat;
        logic        e_done;
        logic        e_pass;
        logic        e_fail;
        logic [7:0]  e_code;
        int          e_cyc;
    } vec_t;

    vec_t tv[7];

    // Reference behaviour of dut_c as a function of the run cycle index.
    function automatic bit m_rdy(input int n);
        return (n % C_SP) < (C_SP - C_SL);
    endfunction

    function automatic bit m_nmi(input int n);
        return (n >= C_NMI) && (n < C_NMI + C_NLEN);
    endfunction

    initial begin
        int          n, hold_rem, post, iter;
        bit          m_done, m_pass, m_fail, m_to, m_acked, q;
        logic [7:0]  m_code;
        int          sel, mode;
        logic [15:0] r_ab;
        logic        r_re, r_we;
        logic [7:0]  r_do;

        tv[0] = '{100, 16'hBEEF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 100};
        tv[1] = '{30,  16'hDEAD, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 30};
        tv[2] = '{7,   16'hBEEF, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 9};
        tv[3] = '{5,   16'hDEAD, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00, 7};
        tv[4] = '{0,   16'hBEEF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0};
        tv[5] = '{12,  16'hBEEE, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 14};
        tv[6] = '{40,  16'hDEAD, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 40};

        // Reset state, then watchdog on the idle dut_b.
        do_reset();
        chk("rst_cpu_reset", a_cr, 1);
        chk("rst_rdy", a_rdy, 1);
        chk("rst_flags", {a_irq, a_nmi, a_done, a_pass, a_fail, a_to}, 0);
        chk("rst_code", a_code, 0);
        chk("rst_cycles", a_cyc, 0);
        iter = 0;
        while (!(b_cyc == 19 && !b_cr) && iter < 200) begin
            @(negedge clk);
            iter++;
        end
        chk("to_reach19", 32'(b_cyc == 19 && !b_cr), 1);
        chk("to_done_early", b_done, 0);
        @(negedge clk);
        chk("to_done", b_done, 1);
        chk("to_flag", b_to, 1);
        chk("to_others", {b_pass, b_fail}, 0);
        chk("to_cpu_reset", b_cr, 1);
        repeat (3) @(negedge clk);
        chk("to_cycles_frozen", b_cyc, 19);

        // Single bus operation scenarios on dut_a.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            wait_a_cycles(tv[i].at);
            a_ab = tv[i].ab; a_re = tv[i].re; a_we = tv[i].we; a_do = tv[i].dat;
            @(negedge clk);
            a_ab = '0; a_re = 0; a_we = 0; a_do = '0;
            @(negedge clk);
            chk($sformatf("tv%0d_done", i), a_done, tv[i].e_done);
            chk($sformatf("tv%0d_pass", i), a_pass, tv[i].e_pass);
            chk($sformatf("tv%0d_fail", i), a_fail, tv[i].e_fail);
            chk($sformatf("tv%0d_to", i), a_to, 0);
            chk($sformatf("tv%0d_code", i), a_code, tv[i].e_code);
            chk($sformatf("tv%0d_cycles", i), a_cyc, tv[i].e_cyc);
            chk($sformatf("tv%0d_cpu_reset", i), a_cr, tv[i].e_done);
        end

        // Reset asserted mid-run; hold sequence afterwards.
        do_reset();
        wait_a_cycles(50);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_cpu_reset", a_cr, 1);
        chk("mid_rdy", a_rdy, 1);
        chk("mid_flags", {a_irq, a_nmi, a_done, a_pass, a_fail, a_to}, 0);
        chk("mid_cycles", a_cyc, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_cpu_reset", k), a_cr, 1);
        end
        @(negedge clk);
        chk("hold_release", a_cr, 0);
        chk("hold_release_cycles", a_cyc, 0);

        // Stall-qualified pass on dut_c: read on an RDY=0 cycle is ignored.
        do_reset();
        wait_c_cycles(3);
        chk("stall_rdy_low", c_rdy, 0);
        c_ab = 16'hBEEF; c_re = 1;
        @(negedge clk);
        chk("stall_ignored", c_done, 0);
        chk("stall_rdy_high", c_rdy, 1);
        @(negedge clk);
        c_ab = '0; c_re = 0;
        chk("stall_pass", c_pass, 1);
        chk("stall_pass_done", c_done, 1);
        chk("stall_pass_cycles", c_cyc, 4);

        // IRQ ack attempted on a stalled cycle (15) then on a ready one (16).
        do_reset();
        wait_c_cycles(0);
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("irqseq%0d_irq", k), c_irq, 32'(k >= 10 && k <= 16));
            chk($sformatf("irqseq%0d_nmi", k), c_nmi, 32'(k == 12 || k == 13));
            chk($sformatf("irqseq%0d_rdy", k), c_rdy, 32'(k % 4 != 3));
            c_ab = (k == 15 || k == 16) ? 16'hFFFE : 16'h0000;
            c_re = (k == 15 || k == 16);
            @(negedge clk);
        end
        c_ab = '0; c_re = 0;

        // Randomised runs on dut_c against the reference model.
        for (int r = 0; r < 8; r++) begin
            mode = r % 3;
            do_reset();
            n = 0; hold_rem = 4; post = 0; iter = 0;
            m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_acked = 0; m_code = '0;
            while (!(m_done && post >= 3) && iter < 400) begin
                if (hold_rem > 0) begin
                    chk("r_hold_cr", c_cr, 1);
                    chk("r_hold_out", {c_irq, c_nmi, c_done, c_pass, c_fail, c_to}, 0);
                    chk("r_hold_rdy", c_rdy, 1);
                    chk("r_hold_cyc", c_cyc, 0);
                end else begin
                    chk("r_cycles", c_cyc, 32'(n));
                    chk("r_cpu_reset", c_cr, 32'(m_done));
                    chk("r_rdy", c_rdy, m_done ? 1 : 32'(m_rdy(n)));
                    chk("r_irq", c_irq, 32'(!m_done && n >= C_IRQ && !m_acked));
                    chk("r_nmi", c_nmi, 32'(!m_done && m_nmi(n)));
                    chk("r_flags", {c_done, c_pass, c_fail, c_to}, {m_done, m_pass, m_fail, m_to});
                    chk("r_code", c_code, m_code);
                end

                sel  = $urandom_range(0, 99);
                r_ab = 16'($urandom);
                r_re = 1'($urandom);
                r_we = 1'($urandom);
                r_do = 8'($urandom);
                if (mode != 1 && sel < 3) begin
                    r_ab = 16'hDEAD; r_we = 1;
                end else if (mode == 0 && sel < 5) begin
                    r_ab = 16'hBEEF; r_re = 1;
                end else if (sel < 25) begin
                    r_ab = 16'hFFFE; r_re = 1;
                end
                c_ab = r_ab; c_re = r_re; c_we = r_we; c_do = r_do;

                if (hold_rem > 0) begin
                    hold_rem--;
                end else if (m_done) begin
                    post++;
                end else begin
                    q = m_rdy(n);
                    if (q && r_we && r_ab == 16'hDEAD) begin
                        m_done = 1; m_fail = 1; m_code = r_do;
                    end else if (q && r_re && r_ab == 16'hBEEF) begin
                        m_done = 1; m_pass = 1;
                    end else if (n == C_TO - 1) begin
                        m_done = 1; m_to = 1;
                    end else begin
                        if (n >= C_IRQ && !m_acked && q && r_re && r_ab == 16'hFFFE)
                            m_acked = 1;
                        n++;
                    end
                end
                @(negedge clk);
                iter++;
            end
            chk($sformatf("rand%0d_finished", r), 32'(m_done), 1);
        end
        c_ab = '0; c_re = 0; c_we = 0; c_do = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
